// File: rtl/noc_pkt_rr_arbiter_if.sv
// Flit-stream bundle between NUM_SRCS upstream sources, the packet arbiter and one downstream port.
// The slave modport is the arbiter's view. The master modport is the surrounding fabric.
interface noc_pkt_rr_arbiter_if #(
   parameter int NUM_SRCS = 4,
   parameter int DATA_W   = 512
);
   logic [NUM_SRCS-1:0]        src_noc_val;
   logic [NUM_SRCS*DATA_W-1:0] src_noc_data;
   logic [NUM_SRCS-1:0]        src_noc_rdy;
   logic                       dst_noc_val;
   logic [DATA_W-1:0]          dst_noc_data;
   logic                       dst_noc_rdy;

   modport master (
      output src_noc_val,
      output src_noc_data,
      output dst_noc_rdy,
      input  src_noc_rdy,
      input  dst_noc_val,
      input  dst_noc_data
   );

   modport slave (
      input  src_noc_val,
      input  src_noc_data,
      input  dst_noc_rdy,
      output src_noc_rdy,
      output dst_noc_val,
      output dst_noc_data
   );
endinterface

// File: rtl/noc_pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_SRCS val/rdy flit streams onto one NoC port.
// The grant locks from a granted header until the packet's last body flit, so packets never interleave.
module noc_pkt_rr_arbiter #(
   parameter int NUM_SRCS = 4,
   parameter int DATA_W   = 512,
   parameter int LEN_W    = 22,
   parameter int LEN_LSB  = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   noc_pkt_rr_arbiter_if.slave         noc,
   output logic [$clog2(NUM_SRCS)-1:0] grant_idx,
   output logic                        busy
);
   localparam int IDX_W = $clog2(NUM_SRCS);
   localparam logic [IDX_W:0]   NUM_SRCS_W = (IDX_W+1)'(NUM_SRCS);
   localparam logic [IDX_W-1:0] RST_GRANT  = IDX_W'(NUM_SRCS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
   logic [LEN_W-1:0]   body_cnt_reg, body_cnt_next;

   logic [DATA_W-1:0]  src_flit [NUM_SRCS];
   logic [IDX_W-1:0]   cand_idx [NUM_SRCS];
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_found;
   logic               in_pass;
   logic [IDX_W-1:0]   cur_idx;
   logic               cur_sel;
   logic               dst_val_int;
   logic [NUM_SRCS-1:0] rdy_vec;
   logic               xfer;
   logic [LEN_W-1:0]   hdr_len;

   // cand_idx[k] is the source holding priority rank k: last_grant+1+k, wrapped modulo NUM_SRCS.
   generate
      for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
         logic [IDX_W:0] sum;
         logic [IDX_W:0] wrapped;

         assign src_flit[gi] = noc.src_noc_data[gi*DATA_W +: DATA_W];
         assign sum          = {1'b0, last_grant_reg} + (IDX_W+1)'(gi + 1);
         assign wrapped      = (sum >= NUM_SRCS_W) ? (sum - NUM_SRCS_W) : sum;
         assign cand_idx[gi] = wrapped[IDX_W-1:0];
         assign rdy_vec[gi]  = rst_n & cur_sel & noc.dst_noc_rdy & (cur_idx == IDX_W'(gi));
      end
   endgenerate

   // Scan from lowest priority to highest so the highest-ranked valid source wins.
   always_comb begin
      rr_idx   = last_grant_reg;
      rr_found = |noc.src_noc_val;
      for (int k = NUM_SRCS - 1; k >= 0; k--) begin
         if (noc.src_noc_val[cand_idx[k]]) begin
            rr_idx = cand_idx[k];
         end
      end
   end

   assign in_pass     = (state_reg == PASS);
   assign cur_idx     = in_pass ? last_grant_reg : rr_idx;
   assign cur_sel     = in_pass | rr_found;
   assign dst_val_int = in_pass ? noc.src_noc_val[last_grant_reg] : rr_found;

   assign noc.dst_noc_val  = rst_n & dst_val_int;
   assign noc.dst_noc_data = cur_sel ? src_flit[cur_idx] : '0;
   assign noc.src_noc_rdy  = rdy_vec;

   assign grant_idx = (rst_n && !in_pass && rr_found) ? rr_idx : last_grant_reg;
   assign busy      = rst_n & in_pass;

   assign xfer    = noc.dst_noc_val & noc.dst_noc_rdy;
   assign hdr_len = noc.dst_noc_data[LEN_LSB +: LEN_W];

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      body_cnt_next   = body_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (xfer) begin
               last_grant_next = rr_idx;
               // A zero-length header is a complete packet; no lock is taken.
               if (hdr_len != '0) begin
                  state_next    = PASS;
                  body_cnt_next = hdr_len;
               end
            end
         end
         PASS: begin
            if (xfer) begin
               body_cnt_next = body_cnt_reg - 1'b1;
               if (body_cnt_reg == LEN_W'(1)) begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= RST_GRANT;
         body_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         body_cnt_reg   <= body_cnt_next;
      end
   end

   a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(noc.src_noc_rdy));

   // The output may only change under stall if the request set itself changed.
   a_dst_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (noc.dst_noc_val && !noc.dst_noc_rdy) |=>
         ($stable(noc.dst_noc_data) || !$stable(noc.src_noc_val)));

   generate
      for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src_chk
         a_val_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (noc.src_noc_val[gi] && !noc.src_noc_rdy[gi]) |=> noc.src_noc_val[gi]);
      end
   endgenerate
endmodule

// File: tb/tb_noc_pkt_rr_arbiter.sv
// Directed bench: per-source flit queues feed the arbiter; an expected-output scoreboard is
// filled in predicted arbitration order and drained at each observed output transfer.
module tb_noc_pkt_rr_arbiter;
   localparam int NS  = 4;
   localparam int DW  = 512;
   localparam int LW  = 22;
   localparam int LSB = 0;
   localparam logic [DW-1:0] FILL = {16{32'hDEADBEEF}};

   typedef struct {
      int            src;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [1:0]    grant_idx;
   logic          busy;

   logic          rst_cmd;
   logic          rdy_cmd;
   logic [NS-1:0] src_en;

   logic [DW-1:0] src_q [NS][$];
   exp_t          exp_q[$];
   int            mdl_left;
   int            checks;
   int            failures;
   int            pkt_no;
   int            n;
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   bit            rdy_pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

   noc_pkt_rr_arbiter_if #(.NUM_SRCS(NS), .DATA_W(DW)) bus ();

   noc_pkt_rr_arbiter #(
      .NUM_SRCS(NS),
      .DATA_W  (DW),
      .LEN_W   (LW),
      .LEN_LSB (LSB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .noc      (bus),
      .grant_idx(grant_idx),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic add_pkt(input int src, input int len);
      logic [DW-1:0] f;
      exp_t          e;
      for (int idx = 0; idx <= len; idx++) begin
         f = {16{$urandom()}};
         f[LSB +: LW]  = (idx == 0) ? LW'(len) : LW'(22'h2A5A5);
         f[DW-1 -: 32] = {8'hA5, 8'(src), 8'(pkt_no), 8'(idx)};
         src_q[src].push_back(f);
         e.src  = src;
         e.data = f;
         exp_q.push_back(e);
      end
      pkt_no++;
   endtask

   task automatic drive();
      rst_n           = rst_cmd;
      bus.dst_noc_rdy = rdy_cmd;
      for (int i = 0; i < NS; i++) begin
         if (src_en[i] && src_q[i].size() > 0) begin
            bus.src_noc_val[i]               = 1'b1;
            bus.src_noc_data[i*DW +: DW]     = src_q[i][0];
         end else begin
            bus.src_noc_val[i]               = 1'b0;
            bus.src_noc_data[i*DW +: DW]     = FILL;
         end
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (!rst_n) begin
         mdl_left = 0;
      end else begin
         chk("busy", DW'(busy), DW'(mdl_left != 0));
         if (bus.src_noc_val == '0 && mdl_left == 0) begin
            chk("idle_val", DW'(bus.dst_noc_val), DW'(0));
            chk("idle_data", bus.dst_noc_data, '0);
         end
         if (bus.dst_noc_val && bus.dst_noc_rdy) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               failures++;
               $error("FAIL unexpected_xfer: got flit tag %h expected none", bus.dst_noc_data[DW-1 -: 32]);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("xfer_data", bus.dst_noc_data, e.data);
               chk("xfer_grant", DW'(grant_idx), DW'(e.src));
               chk("xfer_src_rdy", DW'(bus.src_noc_rdy), DW'(4'b0001 << e.src));
               $display("xfer src=%0d tag=%h len_field=%0d busy=%0b", e.src,
                        bus.dst_noc_data[DW-1 -: 32], bus.dst_noc_data[LSB +: LW], busy);
               if (mdl_left == 0) mdl_left = int'(e.data[LSB +: LW]);
               else mdl_left--;
            end
         end
         for (int i = 0; i < NS; i++) begin
            if (bus.src_noc_val[i] && bus.src_noc_rdy[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
            end
         end
      end
   endtask

   // One clock: apply commands just after the edge, sample at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      monitor();
   endtask

   task automatic run(input int budget, output int cycles);
      cycles = 0;
      while (exp_q.size() > 0 && cycles < budget) begin
         cyc();
         cycles++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL run_timeout: got %0d flits pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      pkt_no   = 0;
      mdl_left = 0;
      rst_cmd  = 1'b0;
      rdy_cmd  = 1'b1;
      src_en   = '1;

      // Reset with every source requesting.
      for (int s = 0; s < NS; s++) add_pkt(s, 0);
      drive();
      cyc();
      cyc();
      chk("rst_dst_val", DW'(bus.dst_noc_val), DW'(0));
      chk("rst_src_rdy", DW'(bus.src_noc_rdy), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_grant_idx", DW'(grant_idx), DW'(NS - 1));
      rst_cmd = 1'b1;
      run(20, n);
      chk("t1_cycles", DW'(n), DW'(4));

      // Four len=2 packets plus a second from source 0: order 0,1,2,3,0 with no gaps.
      for (int s = 0; s < NS; s++) add_pkt(s, 2);
      add_pkt(0, 2);
      run(40, n);
      chk("t2_cycles", DW'(n), DW'(15));

      cyc();

      // Source 0 arrives while source 1 holds the lock.
      src_en[0] = 1'b0;
      add_pkt(1, 3);
      add_pkt(0, 0);
      cyc();
      src_en[0] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         cyc();
         chk("t3_src0_rdy", DW'(bus.src_noc_rdy[0]), DW'(0));
      end
      cyc();
      chk("t3_src0_grant", DW'(grant_idx), DW'(0));
      chk("t3_done", DW'(exp_q.size()), DW'(0));

      // Single-flit packets alternate between sources 2 and 3.
      add_pkt(2, 0);
      add_pkt(3, 0);
      add_pkt(2, 0);
      add_pkt(3, 0);
      run(20, n);
      chk("t4_cycles", DW'(n), DW'(4));

      // Backpressure during a len=4 packet from source 0.
      add_pkt(0, 4);
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int c = 0; c < 8; c++) begin
         rdy_cmd = rdy_pat[c];
         cyc();
         if (prev_stall) chk("t5_stall_data", bus.dst_noc_data, prev_data);
         prev_stall = bus.dst_noc_val && !bus.dst_noc_rdy;
         prev_data  = bus.dst_noc_data;
      end
      chk("t5_done", DW'(exp_q.size()), DW'(0));
      rdy_cmd = 1'b1;

      // Reset with five body flits of a source 1 packet still outstanding.
      add_pkt(1, 8);
      for (int c = 0; c < 4; c++) cyc();
      chk("t6_busy_pre", DW'(busy), DW'(1));
      rst_cmd = 1'b0;
      cyc();
      chk("t6_rst_val", DW'(bus.dst_noc_val), DW'(0));
      chk("t6_rst_busy", DW'(busy), DW'(0));
      src_q[1].delete();
      exp_q.delete();
      add_pkt(0, 0);
      add_pkt(2, 0);
      rst_cmd = 1'b1;
      cyc();
      chk("t6_busy_post", DW'(busy), DW'(0));
      chk("t6_grant_post", DW'(grant_idx), DW'(0));
      run(20, n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
